// File: rtl/uart_rx_fifo_mmio_if.sv
// ---------------------------------------------------------------------------
// uart_rx_fifo_mmio_if
//   Memory-mapped bus between the RISC-V core (master) and the UART receive
//   FIFO register block (slave).
//
//   Signals:
//     addr_i   [3:0]  byte offset: 0x0 RXDATA, 0x4 STATUS, 0x8 CTRL
//     rd_en_i         read strobe, one cycle per access
//     wr_en_i         write strobe, one cycle per access
//     wdata_i  [31:0] write data
//     rdata_o  [31:0] registered read data
//
//   Handshake: there is no valid/ready pair on this bus. Each strobe is a
//   complete single-cycle transfer that the slave always accepts. Read data
//   appears on rdata_o in the cycle after rd_en_i and holds until the next
//   read.
// ---------------------------------------------------------------------------
interface uart_rx_fifo_mmio_if;
    logic [3:0]  addr_i;
    logic        rd_en_i;
    logic        wr_en_i;
    logic [31:0] wdata_i;
    logic [31:0] rdata_o;

    modport master (
        output addr_i,
        output rd_en_i,
        output wr_en_i,
        output wdata_i,
        input  rdata_o
    );

    modport slave (
        input  addr_i,
        input  rd_en_i,
        input  wr_en_i,
        input  wdata_i,
        output rdata_o
    );
endinterface

// File: rtl/uart_rx_fifo_mmio.sv
// ---------------------------------------------------------------------------
// uart_rx_fifo_mmio
//   Consumer stage behind the UART receiver. A completed frame is detected
//   on the falling edge of the receiver's SAVE_DATA_BITS flag; the byte and
//   its parity-error flag are pushed into a synchronous FIFO. The core reads
//   the FIFO through memory-mapped RXDATA / STATUS / CTRL registers; reading
//   RXDATA pops the head entry.
//
//   Parameters:
//     DEPTH   FIFO entries, power of two, 2..64
//     PAR_EN  1: keep receiver parity flag; 0: stored parity flag forced to 0
//
//   Ports:
//     clk              system clock, rising edge
//     rst              synchronous active-high reset
//     rx_data_i  [7:0] received byte from the receiver output register
//     rx_parity_err_i  receiver parity-error flag, qualified with rx_data_i
//     rx_save_i        high while the receiver is in SAVE_DATA_BITS
//     bus              memory-mapped register bus (slave side)
//     irq_o            level interrupt: irq_en & (not_empty | overrun)
//
//   Register map:
//     0x0 RXDATA (read pops): {valid, 22'b0, perr, byte}, 0 when empty
//     0x4 STATUS: [0] not_empty [1] full [2] overrun [3] par_sticky
//                 [8 +: CW] count
//     0x8 CTRL  : write [0] flush [1] clear overrun [2] clear par_sticky
//                 [3] irq_en (read back at bit 3)
// ---------------------------------------------------------------------------
module uart_rx_fifo_mmio #(
    parameter int DEPTH  = 8,
    parameter int PAR_EN = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [7:0]           rx_data_i,
    input  logic                 rx_parity_err_i,
    input  logic                 rx_save_i,
    uart_rx_fifo_mmio_if.slave   bus,
    output logic                 irq_o
);
    localparam int              AW       = $clog2(DEPTH);
    localparam int              CW       = AW + 1;
    localparam logic [CW-1:0]   FULL_CNT = CW'(DEPTH);
    localparam logic            PAR_KEEP = (PAR_EN != 0);

    localparam logic [3:0] ADDR_RXDATA = 4'h0;
    localparam logic [3:0] ADDR_STATUS = 4'h4;
    localparam logic [3:0] ADDR_CTRL   = 4'h8;

    // Storage and state
    logic [8:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          overrun;
    logic          par_sticky;
    logic          irq_en;
    logic          rx_save_q;
    logic [31:0]   rdata_q;

    // Derived control
    logic          push_req;
    logic [8:0]    entry;
    logic          empty;
    logic          full;
    logic          pop_req;
    logic          pop_do;
    logic          ctrl_wr;
    logic          flush;
    logic          push_do;
    logic          ovr_set;
    logic [31:0]   status_word;
    logic [31:0]   rdata_d;

    // Only the low four CTRL bits carry meaning.
    logic unused_wdata;
    assign unused_wdata = ^bus.wdata_i[31:4];

    always_comb begin
        push_req = rx_save_q & ~rx_save_i;
        entry    = {rx_parity_err_i & PAR_KEEP, rx_data_i};
        empty    = (count == '0);
        full     = (count == FULL_CNT);
        pop_req  = bus.rd_en_i & (bus.addr_i == ADDR_RXDATA);
        pop_do   = pop_req & ~empty;
        ctrl_wr  = bus.wr_en_i & (bus.addr_i == ADDR_CTRL);
        flush    = ctrl_wr & bus.wdata_i[0];
        // A pop in the same cycle frees the head slot, so a full FIFO can
        // still take the push. Flush discards the incoming byte silently.
        push_do  = push_req & ~flush & (~full | pop_do);
        ovr_set  = push_req & ~flush & full & ~pop_do;
    end

    always_comb begin
        status_word           = '0;
        status_word[0]        = ~empty;
        status_word[1]        = full;
        status_word[2]        = overrun;
        status_word[3]        = par_sticky;
        status_word[8 +: CW]  = count;
    end

    always_comb begin
        rdata_d = '0;
        case (bus.addr_i)
            ADDR_RXDATA: if (!empty) rdata_d = {1'b1, 22'b0, mem[rd_ptr]};
            ADDR_STATUS: rdata_d = status_word;
            ADDR_CTRL:   rdata_d = {28'b0, irq_en, 3'b0};
            default:     rdata_d = '0;
        endcase
    end

    // Payload storage needs no reset; the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (push_do) mem[wr_ptr] <= entry;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            overrun    <= 1'b0;
            par_sticky <= 1'b0;
            irq_en     <= 1'b0;
            rx_save_q  <= 1'b0;
            rdata_q    <= '0;
        end else begin
            rx_save_q <= rx_save_i;

            if (bus.rd_en_i) rdata_q <= rdata_d;

            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push_do) wr_ptr <= wr_ptr + 1'b1;
                if (pop_do)  rd_ptr <= rd_ptr + 1'b1;
                case ({push_do, pop_do})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: count <= count;
                endcase
            end

            // Clear first so that a coincident set wins.
            if (ctrl_wr) begin
                irq_en <= bus.wdata_i[3];
                if (bus.wdata_i[1]) overrun    <= 1'b0;
                if (bus.wdata_i[2]) par_sticky <= 1'b0;
            end
            if (ovr_set)              overrun    <= 1'b1;
            if (push_do && entry[8])  par_sticky <= 1'b1;
        end
    end

    assign bus.rdata_o = rdata_q;
    assign irq_o       = irq_en & (~empty | overrun);
endmodule

// File: tb/tb_uart_rx_fifo_mmio.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_fifo_mmio
//   Bench for uart_rx_fifo_mmio. A queue-based model tracks FIFO contents
//   and flags; every bus read pushes its expected data into exp_q and a
//   monitor compares it with rdata_o the cycle after the read. irq_o and
//   rdata_o hold behaviour are compared after every cycle. A second DUT with
//   PAR_EN=0 shares the receive stream to check parity masking.
// ---------------------------------------------------------------------------
module tb_uart_rx_fifo_mmio;
    localparam int   DEPTH   = 8;
    localparam logic PAR_BIT = 1'b1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx_save = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_perr = 1'b0;
    logic       irq;
    logic       irq2;

    uart_rx_fifo_mmio_if bus ();
    uart_rx_fifo_mmio_if bus2 ();

    uart_rx_fifo_mmio #(.DEPTH(DEPTH), .PAR_EN(1)) dut (
        .clk             (clk),
        .rst             (rst),
        .rx_data_i       (rx_data),
        .rx_parity_err_i (rx_perr),
        .rx_save_i       (rx_save),
        .bus             (bus),
        .irq_o           (irq)
    );

    uart_rx_fifo_mmio #(.DEPTH(DEPTH), .PAR_EN(0)) dut_nopar (
        .clk             (clk),
        .rst             (rst),
        .rx_data_i       (rx_data),
        .rx_parity_err_i (rx_perr),
        .rx_save_i       (rx_save),
        .bus             (bus2),
        .irq_o           (irq2)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- counters / scoreboard ----------------
    int checks   = 0;
    int failures = 0;
    logic [31:0] exp_q[$];

    // ---------------- reference model ----------------
    logic [8:0]  m_q[$];
    logic        m_prev_save = 1'b0;
    logic        m_ovr       = 1'b0;
    logic        m_ps        = 1'b0;
    logic        m_irq_en    = 1'b0;
    logic [31:0] m_rdata     = '0;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h t=%0t", name, act, req, $time);
        end
    endtask

    function automatic logic [31:0] status_word();
        logic [31:0] s;
        s       = '0;
        s[0]    = (m_q.size() != 0);
        s[1]    = (m_q.size() == DEPTH);
        s[2]    = m_ovr;
        s[3]    = m_ps;
        s[15:8] = 8'(m_q.size());
        return s;
    endfunction

    function automatic logic model_irq();
        return m_irq_en & ((m_q.size() != 0) | m_ovr);
    endfunction

    // ---------------- driver ----------------
    // One clock cycle: apply inputs, advance the model, then check irq_o
    // and (when no read was issued) that rdata_o held its value.
    task automatic step(input logic save, input logic [7:0] d, input logic pe,
                        input logic rd, input logic wr, input logic [3:0] a,
                        input logic [31:0] wd);
        logic        push_req;
        logic        ctrl_wr;
        logic        flush;
        logic        popped;
        logic        was_full;
        logic [8:0]  ent;
        logic [31:0] exp;
        rx_save     = save;
        rx_data     = d;
        rx_perr     = pe;
        bus.rd_en_i = rd;
        bus.wr_en_i = wr;
        bus.addr_i  = a;
        bus.wdata_i = wd;

        push_req    = m_prev_save & ~save;
        m_prev_save = save;
        ctrl_wr     = wr && (a == 4'h8);
        flush       = ctrl_wr && wd[0];
        was_full    = (m_q.size() == DEPTH);
        popped      = 1'b0;
        exp         = '0;

        if (rd) begin
            case (a)
                4'h0: if (m_q.size() > 0) begin
                          exp    = {1'b1, 22'b0, m_q[0]};
                          popped = 1'b1;
                      end
                4'h4: exp = status_word();
                4'h8: exp = {28'b0, m_irq_en, 3'b0};
                default: exp = '0;
            endcase
            exp_q.push_back(exp);
            m_rdata = exp;
        end
        if (popped) void'(m_q.pop_front());
        if (flush) m_q.delete();
        if (ctrl_wr) begin
            m_irq_en = wd[3];
            if (wd[1]) m_ovr = 1'b0;
            if (wd[2]) m_ps  = 1'b0;
        end
        if (push_req && !flush) begin
            ent = {pe & PAR_BIT, d};
            if (!was_full || popped) begin
                m_q.push_back(ent);
                if (ent[8]) m_ps = 1'b1;
            end else begin
                m_ovr = 1'b1;
            end
        end

        @(posedge clk);
        #1;
        check32("irq", {31'b0, irq}, {31'b0, model_irq()});
        if (!rd) check32("rdata_hold", bus.rdata_o, m_rdata);
    endtask

    task automatic idle();
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0);
    endtask

    task automatic rd(input logic [3:0] a);
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, a, 32'h0);
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] wd);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, a, wd);
    endtask

    // Receiver frame: SAVE_DATA_BITS high for nh cycles, then the falling
    // edge cycle carries the byte; an optional bus access rides on that cycle.
    task automatic frame(input logic [7:0] d, input logic pe, input int nh,
                         input logic brd, input logic bwr, input logic [3:0] a,
                         input logic [31:0] wd);
        repeat (nh) step(1'b1, d, pe, 1'b0, 1'b0, 4'h0, 32'h0);
        step(1'b0, d, pe, brd, bwr, a, wd);
    endtask

    task automatic push_byte(input logic [7:0] d, input logic pe);
        frame(d, pe, $urandom_range(1, 3), 1'b0, 1'b0, 4'h0, 32'h0);
    endtask

    task automatic drain();
        while (m_q.size() > 0) rd(4'h0);
    endtask

    task automatic do_reset(input logic save_during);
        rst          = 1'b1;
        rx_save      = save_during;
        bus.rd_en_i  = 1'b0;
        bus.wr_en_i  = 1'b0;
        bus2.rd_en_i = 1'b0;
        bus2.wr_en_i = 1'b0;
        m_q.delete();
        m_ovr       = 1'b0;
        m_ps        = 1'b0;
        m_irq_en    = 1'b0;
        m_prev_save = 1'b0;
        m_rdata     = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check32("reset_rdata", bus.rdata_o, 32'h0);
        check32("reset_irq", {31'b0, irq}, 32'h0);
    endtask

    // ---------------- monitor ----------------
    initial begin
        logic pend;
        logic [31:0] e;
        forever begin
            @(posedge clk);
            pend = bus.rd_en_i & ~rst;
            @(negedge clk);
            if (pend) begin
                if (exp_q.size() == 0) begin
                    check32("rdata_unexpected", bus.rdata_o, 32'hxxxx_xxxx);
                end else begin
                    e = exp_q.pop_front();
                    check32("rdata", bus.rdata_o, e);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [7:0] b;
        logic       save;
        logic       brd;
        logic       bwr;
        logic [3:0] a;
        logic [31:0] wd;

        bus.addr_i   = 4'h0;
        bus.rd_en_i  = 1'b0;
        bus.wr_en_i  = 1'b0;
        bus.wdata_i  = '0;
        bus2.addr_i  = 4'h0;
        bus2.rd_en_i = 1'b0;
        bus2.wr_en_i = 1'b0;
        bus2.wdata_i = '0;

        // Reset state
        do_reset(1'b0);
        rd(4'h4);
        rd(4'h8);
        rd(4'h0);

        // Single byte
        frame(8'hA5, 1'b0, 3, 1'b0, 1'b0, 4'h0, 32'h0);
        rd(4'h0);
        rd(4'h4);

        // Parity flag, sticky and its clear
        push_byte(8'h3C, 1'b1);
        rd(4'h4);
        rd(4'h0);
        wr(4'h8, 32'h4);
        rd(4'h4);

        // PAR_EN=0 instance saw 0xA5 then 0x3C with perr=1
        bus2.addr_i  = 4'h0;
        bus2.rd_en_i = 1'b1;
        idle();
        check32("nopar_rx0", bus2.rdata_o, 32'h800000A5);
        idle();
        bus2.rd_en_i = 1'b0;
        check32("nopar_rx1", bus2.rdata_o, 32'h8000003C);

        // Fill and overrun
        wr(4'h8, 32'h7);
        for (int i = 0; i < DEPTH; i++) push_byte(8'(i), 1'b0);
        rd(4'h4);
        push_byte(8'h08, 1'b0);
        rd(4'h4);
        drain();
        rd(4'h0);
        wr(4'h8, 32'h2);
        rd(4'h4);

        // Wrap with interleaved pushes and pops
        for (int i = 0; i < 20; i++) begin
            b = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 1) == 1) begin
                frame(b, 1'($urandom_range(0, 1)), $urandom_range(1, 3),
                      1'b1, 1'b0, 4'h0, 32'h0);
            end else begin
                push_byte(b, 1'($urandom_range(0, 1)));
                if ($urandom_range(0, 1) == 1) rd(4'h0);
            end
        end
        drain();
        wr(4'h8, 32'h7);

        // Full FIFO: push coincides with a pop
        for (int i = 0; i < DEPTH; i++) push_byte(8'h10 + 8'(i), 1'b0);
        frame(8'h55, 1'b0, 2, 1'b1, 1'b0, 4'h0, 32'h0);
        rd(4'h4);
        drain();
        rd(4'h4);

        // Interrupt
        wr(4'h8, 32'h8);
        rd(4'h8);
        push_byte(8'h61, 1'b0);
        rd(4'h0);
        for (int i = 0; i <= DEPTH; i++) push_byte(8'h70 + 8'(i), 1'b0);
        drain();
        idle();
        wr(4'h8, 32'hA);
        rd(4'h4);
        wr(4'h8, 32'h0);

        // Reset with bytes queued, receiver mid-frame
        for (int i = 0; i < 3; i++) push_byte(8'hC0 + 8'(i), 1'b0);
        do_reset(1'b1);
        idle();
        rd(4'h4);

        // Flush coinciding with push_req
        push_byte(8'h21, 1'b1);
        push_byte(8'h22, 1'b0);
        frame(8'h77, 1'b0, 2, 1'b0, 1'b1, 4'h8, 32'h1);
        rd(4'h4);
        rd(4'h0);
        wr(4'h8, 32'h4);

        // Unmapped and ignored accesses
        push_byte(8'h11, 1'b0);
        rd(4'hC);
        wr(4'h0, 32'hFFFF_FFFF);
        wr(4'h4, 32'hFFFF_FFFF);
        rd(4'h4);
        rd(4'h2);
        rd(4'h0);
        rd(4'h0);

        // Random traffic
        save = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 2) == 0) save = ~save;
            b   = 8'($urandom_range(0, 255));
            brd = ($urandom_range(0, 2) == 0);
            bwr = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 7) == 0) a = 4'($urandom_range(0, 15));
            else a = {2'($urandom_range(0, 2)), 2'b00};
            wd     = 32'($urandom);
            wd[0]  = ($urandom_range(0, 5) == 0);
            step(save, b, 1'($urandom_range(0, 1)), brd, bwr, a, wd);
        end
        idle();
        idle();
        @(negedge clk);
        check32("exp_q_empty", 32'(exp_q.size()), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/uart_rx_fifo_mmio.md
Name: uart_rx_fifo_mmio

Overview:
- Receive-side consumer stage placed directly downstream of the UART receiver.
- Detects each completed frame from the receiver's SAVE_DATA_BITS state flag and captures the received byte plus its parity-error flag.
- Buffers captured entries in a synchronous FIFO.
- Exposes RXDATA / STATUS / CTRL registers to the RISC-V core's memory-mapped bus, with read-to-pop semantics and an optional interrupt.

Parameters:
- DEPTH, 8, FIFO entries; power of two, 2..64.
- PAR_EN, 1, 1 = propagate the receiver parity-error flag; 0 = stored parity flag is forced to 0.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- rx_data_i  input  8  received byte from the UART receiver output register.
- rx_parity_err_i  input  1  receiver parity-error flag, qualified together with rx_data_i.
- rx_save_i  input  1  high while the receiver FSM is in SAVE_DATA_BITS.
- addr_i  input  4  byte address offset: 0x0 RXDATA, 0x4 STATUS, 0x8 CTRL.
- rd_en_i  input  1  bus read strobe, one cycle per access.
- wr_en_i  input  1  bus write strobe, one cycle per access.
- wdata_i  input  32  bus write data.
- rdata_o  output  32  registered read data; valid the cycle after rd_en_i.
- irq_o  output  1  level interrupt.

Behaviour:
- Clock and reset: single clock domain, clk; reset is synchronous, active-high, on rst. All state changes occur on the rising edge of clk.
- Reset state: rdata_o=0, irq_o=0, FIFO empty (wr_ptr=rd_ptr=count=0), overrun=0, par_sticky=0, irq_en=0, rx_save_q=0.
- Frame detect:
  - rx_save_q registers rx_save_i every cycle.
  - push_req = rx_save_q & ~rx_save_i, i.e. the falling edge of rx_save_i.
  - rx_data_i and rx_parity_err_i are stable and correct in the push_req cycle; they are sampled in that cycle.
- Entry format: 9 bits, {perr, byte}, where perr = rx_parity_err_i & PAR_EN.
- Push:
  - If push_req and the FIFO is not full: write the entry at wr_ptr, increment wr_ptr (wraps modulo DEPTH), and set par_sticky if perr=1.
  - If push_req and the FIFO is full: discard the entry and set overrun.
- Pop:
  - pop_req = rd_en_i & (addr_i==0x0).
  - If not empty: rdata_o <= {1'b1, 22'b0, perr, byte}, then rd_ptr increments (wraps).
  - If empty: rdata_o <= 0 and pointers are unchanged.
- Count:
  - Width is $clog2(DEPTH)+1.
  - Push-only: +1. Pop-only: -1. Push and pop in the same cycle: unchanged.
- Simultaneous push and pop when full: the pop is accepted, and the push is also accepted into the freed slot. No overrun; count stays DEPTH.
- Simultaneous push and pop when empty: the pop returns invalid (bit31=0); the push is stored; count becomes 1.
- STATUS read (0x4): rdata_o <= value with
  - [0] not_empty
  - [1] full
  - [2] overrun
  - [3] par_sticky
  - [8 +: CW] count
  - all other bits 0.
- CTRL write (0x8):
  - bit0=1: flush FIFO (pointers and count to 0).
  - bit1=1: clear overrun.
  - bit2=1: clear par_sticky.
  - bit3: irq_en, read/write.
- CTRL read (0x8): returns {28'b0, irq_en, 3'b0}.
- Priority rules:
  - Flush in the same cycle as push_req: flush wins and the incoming byte is discarded, with no overrun set.
  - Set and clear of a sticky flag in the same cycle: set wins.
  - Flush in the same cycle as pop: the pop returns the pre-flush head entry, then the FIFO is empty.
- Unmapped bus accesses: reads from unmapped offsets return 0; writes to unmapped offsets and to 0x0/0x4 are ignored. Neither strobe active: rdata_o holds its previous value.
- irq_o = irq_en & (not_empty | overrun), driven only from registered state (glitch-free).
- Reset mid-frame or mid-access: all state is cleared; a rx_save_i falling edge in the first cycle after reset is not detected, because rx_save_q=0.

Test Plan:
- Single byte: pulse rx_save_i high 3 cycles with rx_data_i=0xA5, perr=0, then read 0x0 -> rdata_o=0x800000A5 one cycle later; STATUS then reads 0x00000000.
- Parity: push 0x3C with rx_parity_err_i=1 (PAR_EN=1) -> RXDATA=0x8000013C, STATUS[3]=1; write CTRL=0x4 -> STATUS[3]=0. With PAR_EN=0 -> RXDATA=0x8000003C.
- Fill and overrun with DEPTH=8:
  - Push 0x00..0x07 -> STATUS=0x00000803 (count 8, full, not_empty).
  - Push a 9th byte 0x08 -> STATUS bit2 set; the eight pops return 0x00..0x07 in order.
  - A ninth pop returns 0x00000000.
- Wrap and concurrency:
  - Interleave 20 pushes and pops so the pointers wrap twice -> data order is preserved.
  - With the FIFO full, push_req coincides with a pop -> no overrun, count stays 8, new byte appears last.
- Interrupt:
  - CTRL=0x8, then push one byte -> irq_o=1.
  - Pop it -> irq_o=0.
  - Force overrun -> irq_o=1 until CTRL=0xA is written with the FIFO empty.
- Reset and flush:
  - Assert rst with 3 bytes queued -> all outputs 0, STATUS=0.
  - Write CTRL=0x1 in the same cycle as push_req -> FIFO empty, no overrun.
